// File: rtl/pca_register_file.sv
`default_nettype none
// pca_register_file: PCA9685 register map with a separately committed LED image,
// ALL_LED broadcast, OCH-controlled commit timing and a SLEEP-exit wake timer.
module pca_register_file #(
  parameter int WAKE_CYCLES  = 12500,
  parameter int LED_CHANNELS = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       soft_rst_ni,
  input  logic [7:0]                 write_register_id_i,
  input  logic [7:0]                 write_register_value_i,
  input  logic                       write_enable_i,
  input  logic                       i2c_stopped_i,
  output logic [0:2047]              register_blob_o,
  output logic [0:LED_CHANNELS*32-1] led_blob_o,
  output logic                       commit_o,
  output logic                       osc_ready_o
);

  localparam int LED_BYTES = 4 * LED_CHANNELS;
  localparam int NUM_REGS  = 6 + LED_BYTES;
  localparam int CNT_W     = (WAKE_CYCLES < 2) ? 1 : $clog2(WAKE_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES);

  function automatic logic [7:0] reset_value(input int idx);
    case (idx)
      0:       return 8'h11;
      1:       return 8'h04;
      2:       return 8'hE2;
      3:       return 8'hE4;
      4:       return 8'hE8;
      5:       return 8'hE0;
      default: return (idx >= 6 && ((idx - 6) % 4) == 3) ? 8'h10 : 8'h00;
    endcase
  endfunction

  logic [7:0]          regs [NUM_REGS];
  logic [7:0]          led  [LED_BYTES];
  logic [7:0]          prescale;
  logic                we_q;
  logic                stop_q;
  logic                pending;
  logic                commit_next;
  logic                waking;
  logic [CNT_W-1:0]    wake_cnt;

  logic                accept;
  logic                stop_rise;
  logic                bcast;
  logic [1:0]          bcast_k;
  logic [NUM_REGS-1:0] wr_hit;
  logic                led_wr;
  logic                och;
  logic                off_active;
  logic                sleep_fall;
  logic                sleep_rise;
  logic                commit_trig;
  logic [7:0]          mode1_next;

  assign accept    = write_enable_i & ~we_q;
  assign stop_rise = i2c_stopped_i & ~stop_q;
  assign bcast     = (write_register_id_i >= 8'hFA) && (write_register_id_i <= 8'hFD);
  // 0xFA..0xFD map onto channel byte 0..3
  assign bcast_k   = write_register_id_i[1:0] + 2'd2;
  assign och       = regs[1][3];

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (accept && write_register_id_i == 8'(i)) wr_hit[i] = 1'b1;
      if (accept && bcast && i >= 6 && ((i - 6) % 4) == int'(bcast_k)) wr_hit[i] = 1'b1;
    end
  end

  assign led_wr = |wr_hit[NUM_REGS-1:6];

  always_comb begin
    off_active = 1'b0;
    for (int n = 0; n < LED_CHANNELS; n++) begin
      if ({led[4*n+3][3:0], led[4*n+2]} != 12'h000) off_active = 1'b1;
    end
  end

  assign sleep_fall = wr_hit[0] & regs[0][4] & ~write_register_value_i[4];
  assign sleep_rise = wr_hit[0] & ~regs[0][4] & write_register_value_i[4];

  // EXTCLK is sticky; RESTART clears on a written 1 and is set by hardware on sleep entry
  always_comb begin
    mode1_next = {regs[0][7] & ~write_register_value_i[7],
                  regs[0][6] | write_register_value_i[6],
                  write_register_value_i[5:0]};
    if (sleep_rise && off_active) mode1_next[7] = 1'b1;
  end

  assign commit_trig = och ? led_wr
                           : (stop_rise & ((pending & ~commit_next) | led_wr));

  always_ff @(posedge clk_i) begin
    if (rst_i || !soft_rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= reset_value(i);
      for (int i = 0; i < LED_BYTES; i++) led[i] <= reset_value(i + 6);
      prescale    <= 8'h1E;
      we_q        <= 1'b1;
      stop_q      <= 1'b1;
      pending     <= 1'b0;
      commit_next <= 1'b0;
      commit_o    <= 1'b0;
      waking      <= 1'b0;
      wake_cnt    <= '0;
      osc_ready_o <= 1'b0;
    end else begin
      we_q   <= write_enable_i;
      stop_q <= i2c_stopped_i;

      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) regs[i] <= (i == 0) ? mode1_next : write_register_value_i;
      end
      if (accept && write_register_id_i == 8'hFE) prescale <= write_register_value_i;

      if (commit_next) begin
        for (int i = 0; i < LED_BYTES; i++) led[i] <= regs[i + 6];
      end
      commit_o    <= commit_next;
      commit_next <= commit_trig;

      if (led_wr) pending <= 1'b1;
      else if (commit_next) pending <= 1'b0;

      if (sleep_fall) begin
        wake_cnt    <= WAKE_LOAD;
        waking      <= 1'b1;
        osc_ready_o <= 1'b0;
      end else if (sleep_rise) begin
        wake_cnt    <= '0;
        waking      <= 1'b0;
        osc_ready_o <= 1'b0;
      end else if (waking) begin
        if (wake_cnt == '0) begin
          waking      <= 1'b0;
          osc_ready_o <= 1'b1;
        end else begin
          wake_cnt <= wake_cnt - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    register_blob_o = '0;
    for (int i = 0; i < NUM_REGS; i++) register_blob_o[i*8 +: 8] = regs[i];
    register_blob_o[254*8 +: 8] = prescale;
  end

  always_comb begin
    led_blob_o = '0;
    for (int i = 0; i < LED_BYTES; i++) led_blob_o[i*8 +: 8] = led[i];
  end

endmodule
`default_nettype wire

// File: doc/pca_register_file.md
Name: pca_register_file

Overview:
- Register storage stage directly downstream of the I2C target.
- Consumes its write strobe, register id and value, plus its software-reset and stop indications.
- Holds the 256-byte PCA9685 register map and returns it as the flat readback blob the target indexes.
- Also drives a separately committed LED-register image for the PWM engine, with ALL_LED broadcast, MODE2.OCH commit timing and a SLEEP-exit oscillator wake timer.

Parameters:
- WAKE_CYCLES, 12500, clk_i cycles the oscillator-ready flag stays low after SLEEP clears (500 us at 25 MHz).
- LED_CHANNELS, 16, number of LED channels; 4 registers each, starting at 0x06.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous, active-high reset.
- soft_rst_ni  input  1  one-cycle active-low software-reset pulse from the I2C target.
- write_register_id_i  input  8  target register address.
- write_register_value_i  input  8  data to write.
- write_enable_i  input  1  write strobe; may stay high several cycles for the same write.
- i2c_stopped_i  input  1  high while the bus is in STOP/idle.
- register_blob_o  output  [0:2047]  readback map; register i at bits [i*8:i*8+7], MSB at the lower index.
- led_blob_o  output  [0:511]  committed image of registers 0x06..0x45, same packing.
- commit_o  output  1  one-cycle pulse when led_blob_o updates.
- osc_ready_o  output  1  high when the oscillator is awake and PWM may run.

Behaviour:
- Reset values, applied on rst_i=1 or soft_rst_ni=0, with identical effect and taking priority over everything else:
  - MODE1 (0x00) = 0x11, MODE2 (0x01) = 0x04.
  - SUBADR1/2/3 (0x02..0x04) = 0xE2/0xE4/0xE8, ALLCALLADR (0x05) = 0xE0.
  - Every LEDn_OFF_H = 0x10; all other LED registers = 0x00.
  - PRE_SCALE (0xFE) = 0x1E; all other bytes = 0x00.
  - led_blob_o equals the reset LED staging contents.
  - commit_o = 0, osc_ready_o = 0 (SLEEP=1), wake counter = 0.
- Write acceptance:
  - A write is accepted on the rising edge of write_enable_i only (registered edge detect). A strobe held high writes once.
  - The target byte updates one cycle after acceptance and is visible on register_blob_o that same cycle.
- Address map:
  - 0x00..0x45: stored as written. Exception: MODE1 bit6 (EXTCLK) is sticky and cannot be cleared by a write; only reset clears it.
  - 0x46..0xF9 and 0xFF: writes ignored; read as 0x00.
  - 0xFA..0xFD (ALL_LED_ON_L..ALL_LED_OFF_H): value k=id-0xFA is written into byte k of every channel, i.e. 0x06+4n+k for n=0..LED_CHANNELS-1, in one cycle. The ALL_LED bytes themselves read 0x00.
  - 0xFE: stored as written; range/SLEEP gating is done upstream.
- LED commit:
  - LED bytes 0x06..0x45 in register_blob_o are the staging copy.
  - Any accepted write to LED staging (direct or broadcast) sets a pending flag.
  - MODE2 bit3 (OCH)=0: commit on the rising edge of i2c_stopped_i while pending.
  - OCH=1: commit the cycle after each LED write is applied.
  - A commit copies staging to led_blob_o, pulses commit_o for 1 cycle and clears pending.
  - A write accepted in the same cycle as a stop edge: the write lands first and the commit on the next cycle includes it.
  - OCH changes take effect on the next write.
  - A stop with nothing pending produces no commit.
- Oscillator/SLEEP, MODE1 bit4:
  - 1->0 transition: load wake counter with WAKE_CYCLES and hold osc_ready_o=0; count down each cycle; osc_ready_o=1 the cycle after the counter reaches 0.
  - 0->1 transition: osc_ready_o=0 next cycle and the counter is cleared.
  - SLEEP re-set mid-countdown aborts the countdown.
- RESTART, MODE1 bit7:
  - Set by hardware when SLEEP goes 0->1 while any LED channel has a nonzero committed OFF value.
  - Writing 1 to it clears it.
  - Writing 0 leaves it unchanged.
- Reset mid-operation: pending, counters and the edge-detect history all clear; a strobe high at reset release is not treated as an edge.

Test Plan:
- Reset, then read register_blob_o -> bytes 0x00=0x11, 0x01=0x04, 0x02=0xE2, 0x05=0xE0, 0x09=0x10, 0xFE=0x1E, 0x50=0x00; osc_ready_o=0, commit_o=0.
- OCH=0; write 0x06=0xAA, 0x07=0x0B with i2c_stopped_i=0 -> staging shows the values, led_blob_o unchanged; raise i2c_stopped_i -> one commit_o pulse, led_blob_o byte0=0xAA, byte1=0x0B.
- Write 0x01=0x0C (OCH=1), then 0x08=0x55 -> commit_o pulses the cycle after the write; led_blob_o byte2=0x55 with no stop.
- Write 0xFD=0x00 then stop -> all 16 LEDn_OFF_H committed as 0x00; 0xFD reads 0x00.
- Write MODE1=0x01 with WAKE_CYCLES=8 -> osc_ready_o rises exactly 9 cycles after the byte updates; write 0x41 (EXTCLK) then 0x01 -> MODE1 reads 0x41.
- Hold write_enable_i high 5 cycles with 0x0A=0x03, assert soft_rst_ni=0 for 1 cycle mid-stream -> all registers return to defaults; no further write until write_enable_i toggles.
